gpsreceiver2_capture: RTL and testbench
=======================================

// Module: gpsreceiver2_capture
// PURPOSE
//  Write side of the GPS sample buffer. Packs 2-bit front-end samples {sign,mag}
//  into bytes and writes them through the byte-wide rxb0 port of gpsreceiver2_memory.
//  The CPU then reads the capture as 32-bit words over Wishbone.
//  Supports single-shot captures of programmable length and a continuous ring mode.
//  Optional start alignment to a 1 ms epoch tick.
// PARAMETERS
//  ADDR_WIDTH  11  byte address width of the rxb0 buffer (2^11 = 2048 bytes)
// PORTS
//  sys_clk     in   1   single clock; the rxb0_clk port of the memory is tied to sys_clk
//  sys_rst_n   in   1   asynchronous active-low reset
//  fe_sign     in   1   front-end sign bit, already synchronous to sys_clk
//  fe_mag      in   1   front-end magnitude bit
//  fe_stb      in   1   sample valid, at most 1 per cycle
//  epoch       in   1   1 ms tick, single-cycle pulse
//  start       in   1   capture start pulse (CSR)
//  stop        in   1   abort pulse (CSR)
//  continuous  in   1   1 = ring mode, 0 = single shot; sampled at start
//  trig_en     in   1   1 = wait for epoch before capturing; sampled at start
//  len         in   ADDR_WIDTH+1  bytes to capture; 0 means 2^ADDR_WIDTH; sampled at start
//  rxb0_dat    out  8   byte to write
//  rxb0_adr    out  ADDR_WIDTH  byte address
//  rxb0_we     out  1   write strobe, 1 cycle per byte
//  busy        out  1   1 in ARMED or CAPTURE
//  done        out  1   level; set on single-shot completion, cleared by start
//  wrapped     out  1   ring mode has wrapped at least once; cleared by start
//  wr_ptr      out  ADDR_WIDTH  next byte address to be written
// BEHAVIOUR
//  Reset (async, sys_rst_n=0): all outputs 0, FSM=IDLE, pack count=0, len_q=0.
//  FSM states: IDLE, ARMED, CAPTURE.
//  - IDLE:
//      start -> latch len/continuous/trig_en; clear done and wrapped; wr_ptr=0, pack=0.
//      Next state: ARMED if trig_en, else CAPTURE.
//  - ARMED: epoch -> CAPTURE. An fe_stb in the same cycle as epoch is the first sample.
//  - CAPTURE: each fe_stb shifts {fe_sign,fe_mag} into the byte, first sample at bits[7:6].
//      Sample 4 of a byte lands at bits[1:0]. On the 4th sample, the next cycle has
//      rxb0_we=1, rxb0_dat=byte, rxb0_adr=wr_ptr; wr_ptr increments in that same cycle.
//      Write latency: 1 cycle from the completing fe_stb.
//  - Single shot: on the write of byte len_q-1 -> IDLE and done=1.
//      len_q=0 captures 2^ADDR_WIDTH bytes.
//  - Ring mode: wr_ptr wraps 2^ADDR_WIDTH-1 -> 0, wrapped=1, capture continues until stop.
//      len is ignored in ring mode.
//  - stop in ARMED or CAPTURE -> IDLE the next cycle. The partial byte is discarded.
//      A write already pending from the previous fe_stb still completes. done stays 0.
//  - stop and start in the same cycle: stop wins. start while busy is ignored.
//  - fe_stb outside CAPTURE is ignored. Back-to-back fe_stb every cycle is sustained
//      with no sample loss.
//  - rxb0_dat and rxb0_adr hold their last value when rxb0_we=0.
//  - busy is combinational from state. done, wrapped and wr_ptr are registered.
//  - All counters are unsigned; wr_ptr arithmetic is modulo 2^ADDR_WIDTH.
// TESTING
//  1. len=2, trig_en=0, start; samples 11,10,01,00,00,01,10,11 ->
//     writes adr0=0xE4 then adr1=0x1B; done=1; busy=0; wr_ptr=2.
//  2. trig_en=1, start; 5 fe_stb before epoch ignored; epoch with fe_stb in the same cycle
//     -> that sample lands at bits[7:6] of byte 0.
//  3. continuous=1, 2049 bytes of fe_stb every cycle -> wraps; byte 2048 written at adr 0;
//     wrapped=1; busy stays 1; done=0.
//  4. len=0 single shot -> exactly 2048 writes (adr 0..2047); done=1 after the last write.
//  5. stop after 6 samples -> one write at adr0, partial byte dropped; IDLE; done=0.
//     stop+start same cycle -> stays IDLE.
//  6. Assert sys_rst_n low mid-capture -> all outputs 0 immediately.
//     After release, start restarts cleanly at adr 0.

Source files
------------

// File: rtl/gpsreceiver2_capture_if.sv
// Signal bundle between the capture engine and its control/front-end side.
// The slave modport is the capture block; the master modport is whoever drives it.
interface gpsreceiver2_capture_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  fe_sign;
  logic                  fe_mag;
  logic                  fe_stb;
  logic                  epoch;
  logic                  start;
  logic                  stop;
  logic                  continuous;
  logic                  trig_en;
  logic [ADDR_WIDTH:0]   len;

  logic [7:0]            rxb0_dat;
  logic [ADDR_WIDTH-1:0] rxb0_adr;
  logic                  rxb0_we;
  logic                  busy;
  logic                  done;
  logic                  wrapped;
  logic [ADDR_WIDTH-1:0] wr_ptr;

  modport slave (
    input  fe_sign, fe_mag, fe_stb, epoch, start, stop, continuous, trig_en, len,
    output rxb0_dat, rxb0_adr, rxb0_we, busy, done, wrapped, wr_ptr
  );

  modport master (
    output fe_sign, fe_mag, fe_stb, epoch, start, stop, continuous, trig_en, len,
    input  rxb0_dat, rxb0_adr, rxb0_we, busy, done, wrapped, wr_ptr
  );
endinterface

// File: rtl/gpsreceiver2_capture.sv
// Packs 2-bit {sign,mag} front-end samples into bytes and writes them to the
// rxb0 byte port of the sample buffer; single-shot or ring capture, optional epoch start.
module gpsreceiver2_capture #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  gpsreceiver2_capture_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  cont_q, cont_d;
  logic [1:0]            packCnt_q, packCnt_d;
  logic [5:0]            shift_q, shift_d;
  logic [7:0]            dat_q, dat_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
  logic                  we_q, we_d;
  logic                  done_q, done_d;
  logic                  wrapped_q, wrapped_d;

  logic                  startGo;
  logic                  abort;
  logic                  sampleTake;
  logic                  byteDone;
  logic                  lastByte;
  logic                  ptrWrap;
  logic [ADDR_WIDTH:0]   lenTarget;
  logic [ADDR_WIDTH:0]   byteCount;

  // stop outranks everything, including a start or a sample in the same cycle
  assign startGo    = (state_q == IDLE) && bus.start && !bus.stop;
  assign abort      = (state_q != IDLE) && bus.stop;
  assign sampleTake = bus.fe_stb && !bus.stop &&
                      ((state_q == CAPTURE) || ((state_q == ARMED) && bus.epoch));
  assign byteDone   = sampleTake && (packCnt_q == 2'd3);

  // a latched length of zero stands for the whole buffer
  assign lenTarget  = (len_q == '0) ? {1'b1, {ADDR_WIDTH{1'b0}}} : len_q;
  assign byteCount  = {1'b0, wrPtr_q} + 1'b1;
  assign lastByte   = byteDone && !cont_q && (byteCount == lenTarget);
  assign ptrWrap    = byteDone && (wrPtr_q == {ADDR_WIDTH{1'b1}});

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (startGo) begin
          state_d = bus.trig_en ? ARMED : CAPTURE;
        end
      end
      ARMED: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.epoch) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (bus.stop || lastByte) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    len_d     = len_q;
    cont_d    = cont_q;
    packCnt_d = packCnt_q;
    shift_d   = shift_q;
    dat_d     = dat_q;
    adr_d     = adr_q;
    wrPtr_d   = wrPtr_q;
    we_d      = 1'b0;
    done_d    = done_q;
    wrapped_d = wrapped_q;

    if (startGo) begin
      len_d     = bus.len;
      cont_d    = bus.continuous;
      done_d    = 1'b0;
      wrapped_d = 1'b0;
      wrPtr_d   = '0;
      packCnt_d = 2'd0;
      shift_d   = '0;
    end

    if (abort) begin
      packCnt_d = 2'd0;
      shift_d   = '0;
    end

    // the first sample of a byte ends up in bits [7:6] after three more shifts
    if (sampleTake) begin
      shift_d   = {shift_q[3:0], bus.fe_sign, bus.fe_mag};
      packCnt_d = packCnt_q + 2'd1;
      if (byteDone) begin
        we_d    = 1'b1;
        dat_d   = {shift_q, bus.fe_sign, bus.fe_mag};
        adr_d   = wrPtr_q;
        wrPtr_d = wrPtr_q + 1'b1;
        if (cont_q && ptrWrap) begin
          wrapped_d = 1'b1;
        end
        if (lastByte) begin
          done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      len_q     <= '0;
      cont_q    <= 1'b0;
      packCnt_q <= 2'd0;
      shift_q   <= '0;
      dat_q     <= '0;
      adr_q     <= '0;
      wrPtr_q   <= '0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      len_q     <= len_d;
      cont_q    <= cont_d;
      packCnt_q <= packCnt_d;
      shift_q   <= shift_d;
      dat_q     <= dat_d;
      adr_q     <= adr_d;
      wrPtr_q   <= wrPtr_d;
      we_q      <= we_d;
      done_q    <= done_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.rxb0_we  = we_q;
  assign bus.rxb0_dat = dat_q;
  assign bus.rxb0_adr = adr_q;
  assign bus.done     = done_q;
  assign bus.wrapped  = wrapped_q;
  assign bus.wr_ptr   = wrPtr_q;

endmodule

// File: tb/tb_gpsreceiver2_capture.sv
// Bench for gpsreceiver2_capture: directed vectors, a sample-level reference model
// compared every cycle, and literal expectations for each scenario.
module tb_gpsreceiver2_capture;

  localparam int AW   = 11;
  localparam int BUFN = 2048;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  gpsreceiver2_capture_if #(.ADDR_WIDTH(AW)) bus();

  gpsreceiver2_capture #(.ADDR_WIDTH(AW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int vectors     = 0;
  int miscompares = 0;
  bit compareOn   = 1'b0;

  // reference model state
  int            mMode = 0;
  int            mSamples[$];
  int            mTarget = 0;
  int            mWritten = 0;
  bit            mCont = 1'b0;
  logic          expWe = 1'b0;
  logic [7:0]    expDat = '0;
  logic [AW-1:0] expAdr = '0;
  logic [AW-1:0] expPtr = '0;
  logic          expBusy = 1'b0;
  logic          expDone = 1'b0;
  logic          expWrapped = 1'b0;

  logic [18:0]   obsLog[$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit stb, input int smp, input bit ep, input bit st, input bit sp);
    bus.fe_stb  = stb;
    bus.fe_sign = smp[1];
    bus.fe_mag  = smp[0];
    bus.epoch   = ep;
    bus.start   = st;
    bus.stop    = sp;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [63:0] dutBundle();
    return {30'b0, bus.rxb0_we, bus.rxb0_dat, bus.rxb0_adr, bus.busy, bus.done, bus.wrapped, bus.wr_ptr};
  endfunction

  function automatic logic [63:0] wrEntry(input int adr, input int dat);
    logic [10:0] a;
    logic [7:0]  d;
    a = adr[10:0];
    d = dat[7:0];
    return {45'b0, a, d};
  endfunction

  // Sample-level model: collects accepted samples, emits a byte write per four samples
  initial begin
    int byteVal;
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) begin
        mMode = 0; mSamples.delete(); mTarget = 0; mWritten = 0; mCont = 1'b0;
        expWe = 1'b0; expDat = '0; expAdr = '0; expPtr = '0;
        expDone = 1'b0; expWrapped = 1'b0;
      end else begin
        expWe = 1'b0;
        if (mMode != 0 && bus.stop) begin
          mMode = 0;
          mSamples.delete();
        end else if (mMode == 0) begin
          if (bus.start && !bus.stop) begin
            mTarget    = (bus.len == 0) ? BUFN : int'(bus.len);
            mCont      = bus.continuous;
            mMode      = bus.trig_en ? 1 : 2;
            expDone    = 1'b0;
            expWrapped = 1'b0;
            expPtr     = '0;
            mWritten   = 0;
            mSamples.delete();
          end
        end else begin
          if (mMode == 1 && bus.epoch) mMode = 2;
          if (mMode == 2 && bus.fe_stb) begin
            mSamples.push_back({30'b0, bus.fe_sign, bus.fe_mag});
            if (mSamples.size() == 4) begin
              byteVal = mSamples[0] * 64 + mSamples[1] * 16 + mSamples[2] * 4 + mSamples[3];
              mSamples.delete();
              expWe  = 1'b1;
              expDat = byteVal[7:0];
              expAdr = expPtr;
              expPtr = expPtr + 1'b1;
              mWritten++;
              if (mCont && expPtr == 0) expWrapped = 1'b1;
              if (!mCont && mWritten == mTarget) begin
                mMode   = 0;
                expDone = 1'b1;
              end
            end
          end
        end
      end
      expBusy = (mMode != 0);
    end
  end

  initial begin
    forever begin
      @(negedge sys_clk);
      if (compareOn && sys_rst_n) begin
        checkOutput("cycle", dutBundle(),
                    {30'b0, expWe, expDat, expAdr, expBusy, expDone, expWrapped, expPtr});
      end
    end
  end

  initial begin
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n && bus.rxb0_we) obsLog.push_back({bus.rxb0_adr, bus.rxb0_dat});
    end
  end

  initial begin
    int t1[8] = '{3, 2, 1, 0, 0, 1, 2, 3};
    int t5[6] = '{3, 2, 1, 0, 1, 1};
    int bad;

    bus.fe_stb = 1'b0; bus.fe_sign = 1'b0; bus.fe_mag = 1'b0; bus.epoch = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.continuous = 1'b0; bus.trig_en = 1'b0;
    bus.len = '0;

    #3;
    checkOutput("reset outputs", dutBundle(), 64'd0);
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    compareOn = 1'b1;
    idle(2);

    // single shot, two bytes
    $display("[TB] single shot len=2");
    bus.len = 12'd2; bus.continuous = 1'b0; bus.trig_en = 1'b0;
    obsLog.delete();
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, t1[i], 1'b0, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b1, 3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 3, 1'b0, 1'b0, 1'b0);
    idle(2);
    checkOutput("t1 write count", obsLog.size(), 2);
    checkOutput("t1 write0", 64'(obsLog[0]), wrEntry(0, 'hE4));
    checkOutput("t1 write1", 64'(obsLog[1]), wrEntry(1, 'h1B));
    checkOutput("t1 done", bus.done, 1);
    checkOutput("t1 busy", bus.busy, 0);
    checkOutput("t1 wr_ptr", bus.wr_ptr, 2);

    // epoch-triggered start
    $display("[TB] epoch trigger");
    bus.len = 12'd1; bus.trig_en = 1'b1;
    obsLog.delete();
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1, 1'b0, 1'b0, 1'b0);
    checkOutput("t2 armed busy", bus.busy, 1);
    checkOutput("t2 armed writes", obsLog.size(), 0);
    applyStimulus(1'b1, 2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 0, 1'b0, 1'b0, 1'b0);
    idle(2);
    checkOutput("t2 write count", obsLog.size(), 1);
    checkOutput("t2 write0", 64'(obsLog[0]), wrEntry(0, 'h80));
    checkOutput("t2 done", bus.done, 1);

    // ring mode across the wrap
    $display("[TB] ring mode wrap");
    bus.continuous = 1'b1; bus.trig_en = 1'b0;
    obsLog.delete();
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < (BUFN + 1) * 4; i++) applyStimulus(1'b1, (i * 5 + i / 7) % 4, 1'b0, 1'b0, 1'b0);
    idle(2);
    checkOutput("t3 write count", obsLog.size(), BUFN + 1);
    checkOutput("t3 last before wrap", 64'(obsLog[BUFN - 1][18:8]), 64'(BUFN - 1));
    checkOutput("t3 wrapped adr", 64'(obsLog[BUFN][18:8]), 64'd0);
    checkOutput("t3 wrapped", bus.wrapped, 1);
    checkOutput("t3 busy", bus.busy, 1);
    checkOutput("t3 done", bus.done, 0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(1);
    checkOutput("t3 busy after stop", bus.busy, 0);

    // len=0 means whole buffer
    $display("[TB] single shot full buffer");
    bus.continuous = 1'b0; bus.len = 12'd0;
    obsLog.delete();
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < BUFN * 4 + 8; i++) applyStimulus(1'b1, (i * 3 + i / 11) % 4, 1'b0, 1'b0, 1'b0);
    idle(2);
    bad = 0;
    foreach (obsLog[k]) if (obsLog[k][18:8] != k[10:0]) bad++;
    checkOutput("t4 write count", obsLog.size(), BUFN);
    checkOutput("t4 adr order", bad, 0);
    checkOutput("t4 done", bus.done, 1);
    checkOutput("t4 busy", bus.busy, 0);
    checkOutput("t4 wr_ptr", bus.wr_ptr, 0);

    // abort mid-byte, start while busy, stop+start together
    $display("[TB] stop handling");
    bus.len = 12'd10;
    obsLog.delete();
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, t5[0], 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, t5[1], 1'b0, 1'b1, 1'b0);
    for (int i = 2; i < 6; i++) applyStimulus(1'b1, t5[i], 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    idle(2);
    checkOutput("t5 write count", obsLog.size(), 1);
    checkOutput("t5 write0", 64'(obsLog[0]), wrEntry(0, 'hE4));
    checkOutput("t5 done", bus.done, 0);
    checkOutput("t5 busy", bus.busy, 0);
    checkOutput("t5 wr_ptr", bus.wr_ptr, 1);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);
    idle(1);
    checkOutput("t5 stop+start busy", bus.busy, 0);
    checkOutput("t5 stop+start wr_ptr", bus.wr_ptr, 1);

    // asynchronous reset in the middle of a ring capture
    $display("[TB] reset mid-capture");
    bus.continuous = 1'b1;
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, i % 4, 1'b0, 1'b0, 1'b0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("t6 async reset", dutBundle(), 64'd0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    idle(1);
    obsLog.delete();
    bus.continuous = 1'b0; bus.len = 12'd1;
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, i, 1'b0, 1'b0, 1'b0);
    idle(2);
    checkOutput("t6 write count", obsLog.size(), 1);
    checkOutput("t6 write0", 64'(obsLog[0]), wrEntry(0, 'h1B));
    checkOutput("t6 done", bus.done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
